// File: rtl/inst_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int unsigned cInstW = 32;
  localparam int unsigned cXLen  = 32;

  // One fetched instruction together with the address it was read from.
  typedef struct packed {
    logic [cXLen-1:0]  pc;
    logic [cInstW-1:0] inst;
  } tFetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush, occupancy count and full/empty flags.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  tFetchEntry    wdata,
  input  logic          pop,
  output tFetchEntry    rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  tFetchEntry    mem_q [DEPTH];
  tFetchEntry    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Next-state: flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Producers size their pushes against free space; overflowing is a design bug.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full_q));
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, in-order memory requests, response buffer toward decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [cXLen-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  output logic              oMemRd,
  output logic [cXLen-1:0]  oMemAddr,
  input  logic              iMemRdy,
  input  logic              iMemDv,
  input  logic [cInstW-1:0] iMemData,
  input  logic              iBranchDv,
  input  logic [cXLen-1:0]  iBranchAddr,
  input  logic              iStall,
  output logic              oInstDv,
  output logic [cInstW-1:0] oInst,
  output logic [cXLen-1:0]  oPc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              oMisalign
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [cXLen-1:0] pc_q, pc_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic             halt;
  logic [cXLen-1:0] br_target;

  logic             accept, pop, keep, room;
  tFetchEntry       pcq_wdata, pcq_head, ibuf_wdata, ibuf_head;
  logic [CW-1:0]    pcq_count, ibuf_count;
  logic             pcq_full, pcq_empty, ibuf_full, ibuf_empty;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q, halt_d;
  assign halt      = halt_q;
  assign br_target = iBranchAddr;
  assign oMisalign = halt_q;
`else
  assign halt      = 1'b0;
  assign br_target = iBranchAddr & ~cXLen'(3);
`endif

  // Issue control. The slot freed by this cycle's pop is credited so that a
  // latency-1 memory sustains one instruction per cycle with DEPTH=2.
  always_comb begin
    pop    = !ibuf_empty && !iStall && !iBranchDv;
    room   = (SW'(outstanding_q) + SW'(ibuf_count) - SW'(pop)) < SW'(DEPTH);
    oMemRd = !iRst && !iBranchDv && !halt && room;
    accept = oMemRd && iMemRdy;
    keep   = iMemDv && (discard_q == '0);
  end

  // Response entry: queued request PC paired with the returned word.
  always_comb begin
    pcq_wdata      = '0;
    pcq_wdata.pc   = pc_q;
    ibuf_wdata     = pcq_head;
    ibuf_wdata.inst = iMemData;
  end

  // Next PC, in-flight and discard counters; a redirect overrides all of them.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(iMemDv);
    discard_d     = discard_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d        = halt_q;
`endif
    if (iMemDv && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    if (accept) begin
      pc_d = pc_q + cXLen'(4);
    end
    if (iBranchDv) begin
      pc_d      = br_target;
      discard_d = outstanding_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d    = (iBranchAddr[1:0] != 2'b00);
`endif
    end
  end

  // State registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q        <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q        <= halt_d;
`endif
    end
  end

  // Occupancy invariants implied by the issue rule.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      assert (pcq_count <= outstanding_q);
      assert (!(accept && pcq_full));
      assert (!(ibuf_full && (outstanding_q != '0)));
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
    .clk   (iClk),
    .rst   (iRst),
    .flush (iBranchDv),
    .push  (accept),
    .wdata (pcq_wdata),
    .pop   (keep && !pcq_empty),
    .rdata (pcq_head),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_inst_buf (
    .clk   (iClk),
    .rst   (iRst),
    .flush (iBranchDv),
    .push  (keep),
    .wdata (ibuf_wdata),
    .pop   (pop),
    .rdata (ibuf_head),
    .count (ibuf_count),
    .full  (ibuf_full),
    .empty (ibuf_empty)
  );

  assign oMemAddr = pc_q;
  assign oInstDv  = !ibuf_empty;
  assign oInst    = ibuf_head.inst;
  assign oPc      = ibuf_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with random latency/ready,
// program-order reference for the delivered instruction stream, directed corners.
module tb_inst_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        iClk, iRst;
  logic        oMemRd;
  logic [31:0] oMemAddr;
  logic        iMemRdy, iMemDv;
  logic [31:0] iMemData;
  logic        iBranchDv;
  logic [31:0] iBranchAddr;
  logic        iStall;
  logic        oInstDv;
  logic [31:0] oInst, oPc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        oMisalign;
`endif

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .oMemRd      (oMemRd),
    .oMemAddr    (oMemAddr),
    .iMemRdy     (iMemRdy),
    .iMemDv      (iMemDv),
    .iMemData    (iMemData),
    .iBranchDv   (iBranchDv),
    .iBranchAddr (iBranchAddr),
    .iStall      (iStall),
    .oInstDv     (oInstDv),
    .oInst       (oInst),
    .oPc         (oPc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .oMisalign   (oMisalign)
`endif
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rdy = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;
  bit force_nrdy = 0;

  logic [31:0] exp_req_pc, exp_out_pc;
  bit          exp_halt;
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  logic [31:0] acc_log[$];

  logic        s_rd, s_dv, s_mis;
  logic [31:0] s_addr, s_pc, s_inst;
  bit          prev_hold, prev_redir;
  logic [31:0] prev_pc, prev_inst;

  // Contents of instruction memory at a given byte address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory, sample at negedge+1, update reference, advance.
  task automatic step();
    logic [31:0] tgt;
    int          rdy;
    if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
      iMemDv   = 1'b1;
      iMemData = word_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end else begin
      iMemDv   = 1'b0;
      iMemData = $urandom;
    end
    iMemRdy = force_nrdy ? 1'b0 : ($urandom_range(99) < rdy_pct);
    #1;
    s_rd = oMemRd; s_dv = oInstDv; s_addr = oMemAddr; s_pc = oPc; s_inst = oInst;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_mis = oMisalign;
    check_eq("misalign_flag", 32'(s_mis), 32'(exp_halt));
`else
    s_mis = 1'b0;
`endif
    if (prev_redir) check_eq("redirect_flushes_out", 32'(s_dv), 32'd0);
    if (prev_hold) begin
      check_eq("stall_hold_dv", 32'(s_dv), 32'd1);
      check_eq("stall_hold_pc", s_pc, prev_pc);
      check_eq("stall_hold_inst", s_inst, prev_inst);
    end
    if (iBranchDv) check_eq("redirect_no_req", 32'(s_rd), 32'd0);
    if (exp_halt) check_eq("halt_no_req", 32'(s_rd), 32'd0);
    if (s_rd && iMemRdy) begin
      check_eq("req_addr", s_addr, exp_req_pc);
      rdy = cyc + $urandom_range(lat_max, lat_min);
      if (rdy < last_rdy) rdy = last_rdy;
      last_rdy = rdy;
      pend_addr.push_back(s_addr);
      pend_rdy.push_back(rdy);
      acc_log.push_back(s_addr);
      exp_req_pc = exp_req_pc + 32'd4;
      check_eq("inflight_le_depth", 32'(pend_addr.size() <= DEPTH), 32'd1);
    end
    if (s_dv && !iStall && !iBranchDv) begin
      check_eq("out_pc", s_pc, exp_out_pc);
      check_eq("out_inst", s_inst, word_of(exp_out_pc));
      exp_out_pc = exp_out_pc + 32'd4;
    end
    prev_hold  = s_dv && iStall && !iBranchDv;
    prev_pc    = s_pc;
    prev_inst  = s_inst;
    prev_redir = iBranchDv;
    if (iBranchDv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt      = iBranchAddr;
      exp_halt = (iBranchAddr[1:0] != 2'b00);
`else
      tgt      = {iBranchAddr[31:2], 2'b00};
`endif
      exp_req_pc = tgt;
      exp_out_pc = tgt;
    end
    @(posedge iClk);
    cyc++;
    @(negedge iClk);
  endtask

  task automatic do_reset();
    iRst = 1'b1; iStall = 1'b0; iBranchDv = 1'b0; iBranchAddr = '0;
    iMemRdy = 1'b0; iMemDv = 1'b0; iMemData = '0;
    pend_addr.delete(); pend_rdy.delete();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    #1;
    check_eq("rst_memrd", 32'(oMemRd), 32'd0);
    check_eq("rst_memaddr", oMemAddr, RESET_PC);
    check_eq("rst_instdv", 32'(oInstDv), 32'd0);
    check_eq("rst_inst", oInst, 32'd0);
    check_eq("rst_pc", oPc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("rst_misalign", 32'(oMisalign), 32'd0);
`endif
    iRst = 1'b0;
    exp_req_pc = RESET_PC; exp_out_pc = RESET_PC; exp_halt = 1'b0;
    prev_hold = 1'b0; prev_redir = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] a);
    iBranchDv = 1'b1; iBranchAddr = a;
    step();
    iBranchDv = 1'b0;
  endtask

  task automatic expect_first_pc(input string tag, input logic [31:0] pc);
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (s_dv) begin
        check_eq(tag, s_pc, pc);
        got = 1;
      end
    end
    if (!got) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] a0, t;
    int          n0;

    do_reset();

    // Latency 1, always ready: back-to-back delivery from RESET_PC.
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) check_eq("first_req", 32'(s_rd), 32'd1);
      if (k == 0) check_eq("first_req_addr", s_addr, RESET_PC);
      if (k == 1) check_eq("first_dv_latency", 32'(s_dv), 32'd0);
      if (k >= 2) check_eq("throughput", 32'(s_dv), 32'd1);
    end

    // Decode stall for 5 cycles: requests stop, head held, stream intact after.
    iStall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k >= 1) check_eq("stall_no_req", 32'(s_rd), 32'd0);
    end
    iStall = 1'b0;
    repeat (8) step();

    // Redirect with two stale requests in flight at latency 3.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && pend_addr.size() != 2; k++) step();
    check_eq("inflight_two", 32'(pend_addr.size()), 32'd2);
    redirect(32'h0000_0100);
    expect_first_pc("redirect_first_pc", 32'h0000_0100);
    repeat (6) step();

    // Memory not ready for 4 cycles: request address held.
    lat_min = 1; lat_max = 1;
    force_nrdy = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) a0 = s_addr;
      else check_eq("addr_hold_nrdy", s_addr, a0);
    end
    force_nrdy = 0;
    repeat (6) step();

    // PC wraps from the top of the address space.
    n0 = acc_log.size();
    redirect(32'hFFFF_FFFC);
    for (int k = 0; k < 10 && acc_log.size() < n0 + 2; k++) step();
    if (acc_log.size() < n0 + 2) begin
      check_eq("wrap_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("wrap_first_addr", acc_log[n0], 32'hFFFF_FFFC);
      check_eq("wrap_next_addr", acc_log[n0 + 1], 32'h0000_0000);
    end
    repeat (6) step();

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect halts fetch until an aligned redirect.
    redirect(32'h0000_0102);
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("misalign_set", 32'(s_mis), 32'd1);
      check_eq("misalign_no_req", 32'(s_rd), 32'd0);
    end
    redirect(32'h0000_0200);
    check_eq("misalign_clear", 32'(oMisalign), 32'd0);
    expect_first_pc("misalign_resume_pc", 32'h0000_0200);
    repeat (4) step();
`endif

    // Randomized traffic: stalls, redirects, variable latency and ready.
    lat_min = 1; lat_max = 4; rdy_pct = 70;
    for (int k = 0; k < 600; k++) begin
      iStall    = ($urandom_range(3) == 0);
      iBranchDv = ($urandom_range(19) == 0);
      t = $urandom;
      if ($urandom_range(3) != 0) t[31:16] = 16'h0000;
      if ($urandom_range(7) == 0) t[31:4] = 28'hFFF_FFFF;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      iBranchAddr = t;
      step();
    end
    iStall = 1'b0; iBranchDv = 1'b0;

    // Reset in the middle of traffic, then restart cleanly.
    do_reset();
    lat_min = 1; lat_max = 2; rdy_pct = 100;
    expect_first_pc("post_reset_first_pc", RESET_PC);
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
